// File: rtl/pong_game_ctrl.sv
// Game-state controller for 2-player pong: scores, ball count, winner and
// overlay enables, with timed pauses between rallies and after game over.
module pong_game_ctrl #(
  parameter int TIMER_CYCLES = 100_000_000,
  parameter int WIN_SCORE    = 5,
  parameter int NUM_BALLS    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       left_miss,
  input  logic       right_miss,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic [3:0] ball,
  output logic       winner,
  output logic       gra_still,
  output logic       show_rule,
  output logic       show_over
);

  typedef enum logic [1:0] {NEWGAME, NEWBALL, PLAY, OVER} state_t;

  localparam logic [26:0] TIMER_LOAD = 27'(TIMER_CYCLES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]  BALLS      = 4'(NUM_BALLS);

  state_t      state;
  logic [26:0] timer;
  logic        btn_q;
  logic        btn_rise;
  logic [3:0]  l_nxt, r_nxt, ball_nxt;
  logic        game_end;

  assign btn_rise = btn & ~btn_q;

  // Post-miss values; left_miss wins when both pulse in the same cycle.
  always_comb begin
    l_nxt    = left_score;
    r_nxt    = right_score;
    ball_nxt = ball - 4'd1;
    if (left_miss)       r_nxt = right_score + 4'd1;
    else if (right_miss) l_nxt = left_score + 4'd1;
    game_end = (l_nxt == WIN) || (r_nxt == WIN) || (ball_nxt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NEWGAME;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      ball        <= BALLS;
      winner      <= 1'b0;
      gra_still   <= 1'b1;
      show_rule   <= 1'b1;
      show_over   <= 1'b0;
      timer       <= 27'd0;
      btn_q       <= 1'b0;
    end else begin
      btn_q <= btn;
      case (state)
        NEWGAME: begin
          if (btn_rise) begin
            left_score  <= 4'd0;
            right_score <= 4'd0;
            ball        <= BALLS;
            timer       <= TIMER_LOAD;
            show_rule   <= 1'b0;
            gra_still   <= 1'b1;
            state       <= NEWBALL;
          end
        end
        NEWBALL: begin
          if (timer == 27'd0) begin
            gra_still <= 1'b0;
            state     <= PLAY;
          end else begin
            timer <= timer - 27'd1;
          end
        end
        PLAY: begin
          if (left_miss || right_miss) begin
            left_score  <= l_nxt;
            right_score <= r_nxt;
            ball        <= ball_nxt;
            timer       <= TIMER_LOAD;
            gra_still   <= 1'b1;
            if (game_end) begin
              winner    <= (r_nxt > l_nxt);
              show_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= NEWBALL;
            end
          end
        end
        OVER: begin
          // Scores stay on screen into NEWGAME until the next start press.
          if (timer == 27'd0) begin
            show_over <= 1'b0;
            show_rule <= 1'b1;
            state     <= NEWGAME;
          end else begin
            timer <= timer - 27'd1;
          end
        end
        default: state <= NEWGAME;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl: two instances (WIN_SCORE 3 and 9) share
// stimulus and are each checked every cycle against a pause/score model.
module tb_pong_game_ctrl;
  localparam int TC = 4;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic reset, btn, left_miss, right_miss;
  logic [3:0] a_ls, a_rs, a_ball, b_ls, b_rs, b_ball;
  logic a_win, a_still, a_rule, a_over, b_win, b_still, b_rule, b_over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.TIMER_CYCLES(TC), .WIN_SCORE(3), .NUM_BALLS(NB)) dut_a (
    .clk(clk), .reset(reset), .btn(btn), .left_miss(left_miss), .right_miss(right_miss),
    .left_score(a_ls), .right_score(a_rs), .ball(a_ball), .winner(a_win),
    .gra_still(a_still), .show_rule(a_rule), .show_over(a_over));

  pong_game_ctrl #(.TIMER_CYCLES(TC), .WIN_SCORE(9), .NUM_BALLS(NB)) dut_b (
    .clk(clk), .reset(reset), .btn(btn), .left_miss(left_miss), .right_miss(right_miss),
    .left_score(b_ls), .right_score(b_rs), .ball(b_ball), .winner(b_win),
    .gra_still(b_still), .show_rule(b_rule), .show_over(b_over));

  // mode: 0 waiting for start, 1 serve pause, 2 rally, 3 game-over pause
  typedef struct {
    int mode;
    int pause;
    int ls;
    int rs;
    int balls;
    int win_flag;
    int bq;
  } mdl_t;

  mdl_t ma, mb;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int win, input logic b,
                                input logic lm, input logic rm, input logic r);
    mdl_t n;
    n = m;
    n.bq = int'(b);
    if (r) begin
      n.mode = 0; n.pause = 0; n.ls = 0; n.rs = 0; n.balls = NB; n.win_flag = 0; n.bq = 0;
      return n;
    end
    case (m.mode)
      0: if (b && m.bq == 0) begin
           n.ls = 0; n.rs = 0; n.balls = NB; n.mode = 1; n.pause = TC;
         end
      1, 3: begin
           n.pause = m.pause - 1;
           if (n.pause == 0) n.mode = (m.mode == 1) ? 2 : 0;
         end
      default: if (lm || rm) begin
           if (lm) n.rs = m.rs + 1;
           else    n.ls = m.ls + 1;
           n.balls = m.balls - 1;
           n.pause = TC;
           if (n.rs == win || n.ls == win || n.balls == 0) begin
             n.mode = 3;
             n.win_flag = (n.rs > n.ls) ? 1 : 0;
           end else begin
             n.mode = 1;
           end
         end
    endcase
    return n;
  endfunction

  task automatic cmp_model();
    chk("a.ls", int'(a_ls), ma.ls);
    chk("a.rs", int'(a_rs), ma.rs);
    chk("a.ball", int'(a_ball), ma.balls);
    chk("a.win", int'(a_win), ma.win_flag);
    chk("a.still", int'(a_still), (ma.mode != 2) ? 1 : 0);
    chk("a.rule", int'(a_rule), (ma.mode == 0) ? 1 : 0);
    chk("a.over", int'(a_over), (ma.mode == 3) ? 1 : 0);
    chk("b.ls", int'(b_ls), mb.ls);
    chk("b.rs", int'(b_rs), mb.rs);
    chk("b.ball", int'(b_ball), mb.balls);
    chk("b.win", int'(b_win), mb.win_flag);
    chk("b.still", int'(b_still), (mb.mode != 2) ? 1 : 0);
    chk("b.rule", int'(b_rule), (mb.mode == 0) ? 1 : 0);
    chk("b.over", int'(b_over), (mb.mode == 3) ? 1 : 0);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next one.
  task automatic tick(input logic b, input logic lm, input logic rm, input logic r);
    btn = b; left_miss = lm; right_miss = rm; reset = r;
    @(posedge clk);
    ma = step(ma, 3, b, lm, rm, r);
    mb = step(mb, 9, b, lm, rm, r);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic b_lvl, lm, rm, r;
    btn = 1'b0; left_miss = 1'b0; right_miss = 1'b0; reset = 1'b1;
    ma = '{0, 0, 0, 0, NB, 0, 0};
    mb = ma;
    @(negedge clk);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.ball", int'(a_ball), 5);
    chk("rst.rule", int'(a_rule), 1);
    chk("rst.still", int'(a_still), 1);

    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start.still", int'(a_still), 0);
    chk("start.rule", int'(a_rule), 0);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("miss1.rs", int'(a_rs), 1);
    chk("miss1.ls", int'(a_ls), 0);
    chk("miss1.ball", int'(a_ball), 4);
    chk("miss1.still", int'(a_still), 0);

    tick(1'b0, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("both.rs", int'(a_rs), 2);
    chk("both.ls", int'(a_ls), 0);
    chk("both.ball", int'(a_ball), 3);

    tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("win.over", int'(a_over), 1);
    chk("win.winner", int'(a_win), 1);
    chk("win.b_over", int'(b_over), 0);
    idle(4);
    chk("over_end.rule", int'(a_rule), 1);
    chk("over_end.rs", int'(a_rs), 3);
    chk("over_end.ls", int'(a_ls), 0);

    tick(1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_end.over", int'(b_over), 1);
    chk("b_end.winner", int'(b_win), 1);
    chk("b_end.ball", int'(b_ball), 0);
    chk("b_end.ls", int'(b_ls), 2);
    chk("b_end.rs", int'(b_rs), 3);
    idle(5);

    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart.ls", int'(a_ls), 0);
    chk("restart.rs", int'(a_rs), 0);
    chk("restart.ball", int'(b_ball), 5);
    idle(5);
    chk("midplay.still", int'(a_still), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst.rule", int'(a_rule), 1);
    chk("midrst.still", int'(a_still), 1);
    chk("midrst.ball", int'(a_ball), 5);

    b_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) b_lvl = ~b_lvl;
      lm = ($urandom_range(0, 5) == 0);
      rm = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 399) == 0);
      tick(b_lvl, lm, rm, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-state controller for the 2-player pong. It produces every dynamic value the text overlay consumes: both score digits, the ball digit, the winner flag, and the rule/over screen enables.
- It consumes miss pulses from the graphics block and a start button. It drives gra_still to freeze the ball and paddles between rallies.
- All state is in a single clock domain.

Parameters:
- TIMER_CYCLES, 100_000_000, length of the NEWBALL and OVER pauses in clk cycles (2 s at 50 MHz); legal range 1..2^27-1.
- WIN_SCORE, 5, score that ends the game immediately; legal range 1..9.
- NUM_BALLS, 9, balls per game; legal range 1..9, odd values only, so no tie is possible.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn  in  1  start button, level input, already debounced.
- left_miss  in  1  one-cycle pulse: ball passed the left wall, so the right player scores.
- right_miss  in  1  one-cycle pulse: ball passed the right wall, so the left player scores.
- left_score  out  4  left score, BCD digit 0..9.
- right_score  out  4  right score, BCD digit 0..9.
- ball  out  4  balls remaining, BCD digit 0..9.
- winner  out  1  0 = left (Blue) won, 1 = right (Red) won.
- gra_still  out  1  1 freezes ball and paddles.
- show_rule  out  1  enables the rule text.
- show_over  out  1  enables the game-over text.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. Every output is a register or is decoded only from the state register; there is no combinational path from input to output.
- Reset (any time, including mid-rally or mid-timer) gives: state NEWGAME, left_score=0, right_score=0, ball=NUM_BALLS, winner=0, gra_still=1, show_rule=1, show_over=0, timer=0, btn edge register=0.
- Button edge: btn_q is btn delayed one cycle; btn_rise = btn & ~btn_q. Holding btn produces exactly one event.
- Timer: 27-bit down counter. It is loaded with TIMER_CYCLES-1 on the transition into NEWBALL or OVER and decrements once per cycle in those states. The state exits in the cycle where timer==0, so each pause lasts exactly TIMER_CYCLES cycles.
- NEWGAME:
  - Outputs: show_rule=1, show_over=0, gra_still=1.
  - On btn_rise: clear both scores, set ball=NUM_BALLS, load timer, go to NEWBALL.
  - Miss pulses are ignored.
- NEWBALL:
  - Outputs: gra_still=1, show_rule=0, show_over=0.
  - When timer==0, go to PLAY.
  - Miss pulses and btn are ignored.
- PLAY:
  - Output: gra_still=0.
  - left_miss has priority. If left_miss and right_miss are both high in one cycle, only left_miss is processed and right_miss is dropped.
  - On left_miss: right_score+1 and ball-1, both in the same cycle.
  - On right_miss: left_score+1 and ball-1.
  - After a miss, next state is OVER if the new score equals WIN_SCORE or the new ball equals 0; otherwise NEWBALL. Either way the timer is loaded.
  - On entry to OVER, winner is set to (new right_score > new left_score), computed from the post-increment values.
  - Score arithmetic is 4-bit. Parameter limits guarantee values never exceed 9, so no BCD wrap logic is required.
- OVER:
  - Outputs: show_over=1, gra_still=1, show_rule=0.
  - Scores, ball and winner hold so they stay visible.
  - When timer==0, go to NEWGAME. Scores remain displayed until the next btn_rise clears them.
  - btn and miss pulses are ignored during the timer.
- winner changes only on entry to OVER or on reset.

Test Plan (TIMER_CYCLES=4, WIN_SCORE=3, NUM_BALLS=5 unless stated):
1. Reset asserted for 2 cycles -> left_score=0, right_score=0, ball=5, winner=0, show_rule=1, show_over=0, gra_still=1.
2. btn high for 10 cycles -> one NEWBALL entry; show_rule=0; gra_still=1 for exactly 4 cycles, then 0 (PLAY). btn is still high but no second event occurs.
3. In PLAY, left_miss pulse -> right_score=1, ball=4, gra_still=1 for 4 cycles, then PLAY. A right_miss pulse during NEWBALL is ignored.
4. In PLAY, left_miss and right_miss in the same cycle -> right_score+1 only, left_score unchanged, ball-1.
5. Three left_miss rallies -> right_score=3, OVER, winner=1, show_over=1. After 4 cycles show_rule=1, scores still 0:3. Next btn_rise -> scores 0:0, ball=5.
6. With WIN_SCORE=9, misses L,R,L,R,L -> right 3, left 2, ball 0, OVER, winner=1. In a separate run, reset asserted mid-PLAY -> all reset values next cycle.
